// File: rtl/pattern_tx.sv
// Serial pattern transmitter: a 12-bit word goes out MSB first, each bit held BIT_CYCLES clocks.
// Optional feature: define DEADLOCK_GUARD_EN to accept but drop words whose top nibble is 4'b1110.
module pattern_tx #(
  parameter int BIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        ser_out,
  output logic        ser_valid,
  output logic        frame_start,
  output logic        frame_done,
  output logic        reject
);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  localparam logic [3:0] HOLD_LAST = 4'(BIT_CYCLES - 1);
  localparam logic [3:0] BIT_LAST  = 4'd11;

  state_t      state_reg, state_next;
  logic [11:0] shift_reg;
  logic [3:0]  bit_cnt_reg;
  logic [3:0]  hold_cnt_reg;
  logic        reject_reg;

  logic accept, guard_hit, start, bit_end, frame_end;

`ifdef DEADLOCK_GUARD_EN
  assign guard_hit = (in_data[11:8] == 4'b1110);
`else
  assign guard_hit = 1'b0;
`endif

  // A guarded word still completes the handshake; it just never leaves IDLE.
  assign accept    = (state_reg == IDLE) && in_valid;
  assign start     = accept && !guard_hit;
  assign bit_end   = (hold_cnt_reg == HOLD_LAST);
  assign frame_end = bit_end && (bit_cnt_reg == BIT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (frame_end) state_next = GAP;
      GAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_reg    <= '0;
      bit_cnt_reg  <= '0;
      hold_cnt_reg <= '0;
      reject_reg   <= 1'b0;
    end else begin
      reject_reg <= accept && guard_hit;
      if (state_reg == IDLE) begin
        if (start) begin
          shift_reg    <= in_data;
          bit_cnt_reg  <= '0;
          hold_cnt_reg <= '0;
        end
      end else if (state_reg == SHIFT) begin
        if (bit_end) begin
          hold_cnt_reg <= '0;
          shift_reg    <= {shift_reg[10:0], 1'b0};
          bit_cnt_reg  <= bit_cnt_reg + 4'd1;
        end else begin
          hold_cnt_reg <= hold_cnt_reg + 4'd1;
        end
      end
    end
  end

  always_comb begin
    in_ready    = 1'b0;
    ser_out     = 1'b0;
    ser_valid   = 1'b0;
    frame_start = 1'b0;
    frame_done  = 1'b0;
    case (state_reg)
      IDLE:  in_ready = 1'b1;
      SHIFT: begin
        ser_valid   = 1'b1;
        ser_out     = shift_reg[11];
        frame_start = (bit_cnt_reg == 4'd0) && (hold_cnt_reg == 4'd0);
      end
      GAP:   frame_done = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  assign reject = reject_reg;

endmodule

// File: doc/pattern_tx.md
PATTERN_TX -- requirements
Module: pattern_tx

Interface
REQ-001 Parameter BIT_CYCLES, default 2, clock cycles each serial bit is held (legal range 1..15).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset is synchronous and active-low.
REQ-004 in_data  input  12  word to transmit; bit 11 is sent first.
REQ-005 in_valid  input  1  in_data is valid this cycle.
REQ-006 in_ready  output  1  block can accept a word this cycle.
REQ-007 ser_out  output  1  serial data bit.
REQ-008 ser_valid  output  1  ser_out carries a frame bit this cycle.
REQ-009 frame_start  output  1  one-cycle pulse on the first cycle of bit 11.
REQ-010 frame_done  output  1  one-cycle pulse after the last bit period of a frame.
REQ-011 reject  output  1  one-cycle pulse when a word is discarded by the guard (see REQ-026).

Function
REQ-012 FSM states SHALL be IDLE, SHIFT, GAP; the encoding is implementation-defined, and no other reachable state SHALL exist.
REQ-013 IDLE: in_ready=1, ser_valid=0, ser_out=0.
REQ-014 Handshake: a word SHALL be accepted only on an edge where in_valid=1 and in_ready=1.
REQ-015 On acceptance, capture in_data into a 12-bit shift register, clear the bit counter and the hold counter, and go to SHIFT.
REQ-016 SHIFT: ser_valid=1, ser_out=shift register bit 11, in_ready=0.
REQ-017 Bit 11 SHALL appear on ser_out in the cycle immediately after the acceptance edge; latency is 1 cycle.
REQ-018 Each bit SHALL be held for exactly BIT_CYCLES cycles, then the register shifts left by one.
REQ-019 After the 12th bit period, go to GAP; a frame occupies exactly 12*BIT_CYCLES SHIFT cycles.
REQ-020 GAP lasts 1 cycle: frame_done=1, ser_valid=0, ser_out=0, in_ready=0; then return to IDLE.
REQ-021 in_data and in_valid SHALL be ignored outside IDLE; no word is queued.
REQ-022 Back-to-back words: minimum acceptance spacing is 12*BIT_CYCLES+2 cycles.

Reset
REQ-023 When rst_n=0 at an edge, the FSM SHALL go to IDLE and clear the shift register and both counters.
REQ-024 Output values in reset: in_ready=1, ser_out=0, ser_valid=0, frame_start=0, frame_done=0, reject=0.
REQ-025 Reset in SHIFT or GAP SHALL abort the frame with no frame_done; reset has priority over acceptance in the same cycle.

Configuration
REQ-026 Macro DEADLOCK_GUARD_EN defined: a word with in_data[11:8]=4'b1110 SHALL be accepted (handshake completes) but not transmitted.
REQ-027 For such a guarded word, reject=1 on the next cycle, the FSM stays in IDLE, and ser_valid stays 0.
REQ-028 Macro DEADLOCK_GUARD_EN undefined: every accepted word is transmitted and reject is tied to 0.

Verification
REQ-029 BIT_CYCLES=2, in_data=12'h179 accepted at edge 0:
- ser_out for cycles 1-24 = 0,0,0,1,0,1,1,1,1,0,0,1, each bit held 2 cycles.
- frame_start=1 in cycle 1 only.
- frame_done=1 in cycle 25.
- in_ready=1 again in cycle 26.
REQ-030 BIT_CYCLES=1, in_valid held high with 12'hFFF then 12'h000:
- second acceptance occurs exactly 14 cycles after the first.
- in_ready=0 for cycles 1-13.
REQ-031 BIT_CYCLES=2, 12'h179 in flight, rst_n=0 during the 6th bit period:
- next cycle: ser_valid=0 and in_ready=1.
- frame_done never pulses.
REQ-032 DEADLOCK_GUARD_EN defined, in_data=12'hE00:
- reject=1 for one cycle.
- ser_valid=0 throughout.
- in_ready remains 1.
REQ-033 DEADLOCK_GUARD_EN undefined, in_data=12'hE00:
- full frame 1,1,1,0,0,0,0,0,0,0,0,0 is transmitted.
- reject=0 throughout.
REQ-034 in_valid=1 with in_data changing every cycle during SHIFT: the transmitted bits match the word captured at acceptance.
